// File: rtl/vme_cmd_sequencer.sv
// vme_cmd_sequencer
//
// Runs one VME bus cycle for each command word from the simulation command
// source. It drives address, data and strobes toward the TMB VME slave logic.
// It returns read data and completion status, then asks for the next command.
//
// Optional feature macro: VME_SEQ_TIMEOUT_EN
//   When defined, a DTACK watchdog forces the cycle to complete after TIMEOUT
//   cycles of waiting. Bit 31 of the result then flags a bus error, and read
//   data comes back as 16'hDEAD.
//   When undefined, the sequencer waits for DTACK indefinitely and bit 31 is
//   always 0.
//
// Parameters:
//   ADDR_SETUP      cycles of address strobe before the data strobe (1..15)
//   TIMEOUT         DTACK wait limit in cycles (8-bit counter)
//
// Ports:
//   clk             sole clock, rising edge
//   rst             synchronous active-high reset
//   start           command valid, sampled only while vme_cmd_rd=1
//   vme_cmd_reg     [15:0] offset, [23:16] base, [24] write, [25] read
//   vme_dat_reg_in  [15:0] write data
//   vme_cmd_rd      ready for next command (decoded from state)
//   vme_dat_wr      one-cycle completion strobe
//   vme_dat_reg_out [15:0] read data, [31] bus error
//   vme_adr         latched bus address
//   vme_d_out       latched write data
//   vme_d_oe        data drive enable for write cycles
//   vme_d_in        read data from slave
//   vme_as_n        address strobe, active low
//   vme_ds_n        data strobe, active low
//   vme_write_n     write qualifier, active low
//   vme_dtack_n     asynchronous acknowledge from slave, active low
module vme_cmd_sequencer #(
    parameter int ADDR_SETUP = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] vme_cmd_reg,
    input  logic [31:0] vme_dat_reg_in,
    output logic        vme_cmd_rd,
    output logic        vme_dat_wr,
    output logic [31:0] vme_dat_reg_out,
    output logic [23:0] vme_adr,
    output logic [15:0] vme_d_out,
    output logic        vme_d_oe,
    input  logic [15:0] vme_d_in,
    output logic        vme_as_n,
    output logic        vme_ds_n,
    output logic        vme_write_n,
    input  logic        vme_dtack_n
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        STROBE,
        RELEASE,
        DONE
    } state_t;

    localparam logic [3:0] SETUP_LAST = 4'(ADDR_SETUP - 1);

    state_t      state;
    state_t      next_state;
    logic        dtack_meta;
    logic        dtack_s;
    logic [3:0]  setup_cnt;
    logic        cyc_write;
    logic        cyc_read;
    logic [15:0] rd_data;
    logic        bus_err;
    logic        timeout_hit;
    logic        tmo_fire;
    logic        cmd_read;
    logic        cmd_write;
    logic        next_write;
    logic        next_err;
    logic [31:0] done_word;
    logic        unused_bits;

    // Read has priority when both direction bits are set.
    assign cmd_read  = vme_cmd_reg[25];
    assign cmd_write = vme_cmd_reg[24] & ~vme_cmd_reg[25];

    assign unused_bits = ^{vme_cmd_reg[31:26], vme_dat_reg_in[31:16], 8'(TIMEOUT)};

`ifdef VME_SEQ_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // The counter restarts on every state change, so it measures the time
    // spent waiting in the current STROBE or RELEASE phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (next_state != state) begin
            tmo_cnt <= '0;
        end else if (state == STROBE || state == RELEASE) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    assign timeout_hit = (state == STROBE || state == RELEASE) && (tmo_cnt == 8'(TIMEOUT));
`else
    assign timeout_hit = 1'b0;
`endif

    // A real acknowledge wins over a simultaneous timeout.
    always_comb begin
        next_state = state;
        tmo_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (vme_cmd_reg[25] | vme_cmd_reg[24]) ? ADDR : DONE;
                end
            end
            ADDR: begin
                if (setup_cnt == SETUP_LAST) begin
                    next_state = STROBE;
                end
            end
            STROBE: begin
                if (!dtack_s) begin
                    next_state = RELEASE;
                end else if (timeout_hit) begin
                    next_state = RELEASE;
                    tmo_fire   = 1'b1;
                end
            end
            RELEASE: begin
                if (dtack_s) begin
                    next_state = DONE;
                end else if (timeout_hit) begin
                    next_state = DONE;
                    tmo_fire   = 1'b1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs are registered from next_state so that they line up with the
    // state they belong to. In IDLE the direction comes straight from the
    // command word because it has not been latched yet.
    assign next_write = (state == IDLE) ? cmd_write : cyc_write;
    assign next_err   = bus_err | tmo_fire;

    always_comb begin
        done_word = 32'h0;
        if (state != IDLE) begin
            done_word[31] = next_err;
            if (cyc_read) begin
                done_word[15:0] = next_err ? 16'hDEAD : rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            dtack_meta      <= 1'b1;
            dtack_s         <= 1'b1;
            setup_cnt       <= 4'd0;
            cyc_write       <= 1'b0;
            cyc_read        <= 1'b0;
            rd_data         <= 16'h0;
            bus_err         <= 1'b0;
            vme_dat_wr      <= 1'b0;
            vme_dat_reg_out <= 32'h0;
            vme_adr         <= 24'h0;
            vme_d_out       <= 16'h0;
            vme_d_oe        <= 1'b0;
            vme_as_n        <= 1'b1;
            vme_ds_n        <= 1'b1;
            vme_write_n     <= 1'b1;
        end else begin
            state      <= next_state;
            dtack_meta <= vme_dtack_n;
            dtack_s    <= dtack_meta;
            setup_cnt  <= (state == ADDR) ? setup_cnt + 4'd1 : 4'd0;

            if (state == IDLE && start) begin
                vme_adr   <= vme_cmd_reg[23:0];
                vme_d_out <= vme_dat_reg_in[15:0];
                cyc_write <= cmd_write;
                cyc_read  <= cmd_read;
                bus_err   <= 1'b0;
            end else if (tmo_fire) begin
                bus_err <= 1'b1;
            end

            if (state == STROBE && !dtack_s && cyc_read) begin
                rd_data <= vme_d_in;
            end

            vme_as_n    <= ~(next_state == ADDR || next_state == STROBE);
            vme_ds_n    <= ~(next_state == STROBE);
            vme_write_n <= ~(next_write && (next_state == ADDR || next_state == STROBE));
            vme_d_oe    <= next_write &&
                           (next_state == ADDR || next_state == STROBE || next_state == RELEASE);
            vme_dat_wr  <= (next_state == DONE);

            if (next_state == DONE) begin
                vme_dat_reg_out <= done_word;
            end
        end
    end

    assign vme_cmd_rd = (state == IDLE) && !rst;

endmodule
